// File: rtl/frac_pkg.sv
// Shared types and defaults for the fraction reducer and its serial divider.
package frac_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_GCD,
        DIV_NUM,
        DIV_DEN,
        DONE
    } state_t;

    typedef enum logic {
        DIV_IDLE,
        DIV_RUN
    } div_state_t;

endpackage

// File: rtl/div_serial.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
module div_serial
    import frac_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic             done_o
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_t       st;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic             done;
    logic [2*WIDTH-1:0] step_res;

    function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] r,
                                                    input logic [WIDTH-1:0] q,
                                                    input logic [WIDTH-1:0] d);
        logic [WIDTH:0]   trial;
        logic [WIDTH:0]   diff;
        logic [WIDTH-1:0] nr;
        logic [WIDTH-1:0] nq;
        trial = {r, q[WIDTH-1]};
        diff  = trial - {1'b0, d};
        if (trial >= {1'b0, d}) begin
            nr = diff[WIDTH-1:0];
            nq = {q[WIDTH-2:0], 1'b1};
        end else begin
            nr = trial[WIDTH-1:0];
            nq = {q[WIDTH-2:0], 1'b0};
        end
        return {nr, nq};
    endfunction

    // The first quotient bit is resolved on the load edge, so the last one
    // lands exactly WIDTH cycles after load.
    always_comb begin
        step_res = div_step(rem, quo, dvs);
        if (load_i) begin
            step_res = div_step('0, dividend_i, divisor_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st   <= DIV_IDLE;
            cnt  <= '0;
            rem  <= '0;
            quo  <= '0;
            dvs  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load_i) begin
                dvs        <= divisor_i;
                {rem, quo} <= step_res;
                cnt        <= CW'(WIDTH - 1);
                st         <= (WIDTH == 1) ? DIV_IDLE : DIV_RUN;
                done       <= (WIDTH == 1);
            end else if (st == DIV_RUN) begin
                {rem, quo} <= step_res;
                cnt        <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    st   <= DIV_IDLE;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient_o = quo;
    assign done_o     = done;

endmodule

// File: rtl/frac_reduce.sv
// Reduces num/den by an externally supplied gcd, reusing one serial divider
// for numerator and denominator.
module frac_reduce
    import frac_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] num_i,
    input  logic [WIDTH-1:0] den_i,
    input  logic             gcd_valid_i,
    input  logic [WIDTH-1:0] gcd_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] num_o,
    output logic [WIDTH-1:0] den_o,
    output logic             err_o
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] num_q;
    logic [WIDTH-1:0] den_q;
    logic [WIDTH-1:0] gcd_q;
    logic             div_load;
    logic [WIDTH-1:0] div_dividend;
    logic [WIDTH-1:0] div_divisor;
    logic [WIDTH-1:0] div_quo;
    logic             div_done;

    div_serial #(.WIDTH(WIDTH)) u_div (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (div_load),
        .dividend_i (div_dividend),
        .divisor_i  (div_divisor),
        .quotient_o (div_quo),
        .done_o     (div_done)
    );

    always_comb begin
        state_nxt    = state;
        div_load     = 1'b0;
        div_dividend = num_q;
        div_divisor  = gcd_i;
        case (state)
            IDLE:     if (start_i) state_nxt = WAIT_GCD;
            WAIT_GCD: begin
                if (gcd_valid_i) begin
                    if (gcd_i == '0 || gcd_i == WIDTH'(1)) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = DIV_NUM;
                        div_load  = 1'b1;
                    end
                end
            end
            DIV_NUM: begin
                if (div_done) begin
                    state_nxt    = DIV_DEN;
                    div_load     = 1'b1;
                    div_dividend = den_q;
                    div_divisor  = gcd_q;
                end
            end
            DIV_DEN:  if (div_done) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            num_q <= '0;
            den_q <= '0;
            gcd_q <= '0;
            num_o <= '0;
            den_o <= '0;
            err_o <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        num_q <= num_i;
                        den_q <= den_i;
                    end
                end
                WAIT_GCD: begin
                    if (gcd_valid_i) begin
                        gcd_q <= gcd_i;
                        if (gcd_i == '0) begin
                            num_o <= '0;
                            den_o <= '0;
                            err_o <= 1'b1;
                        end else if (gcd_i == WIDTH'(1)) begin
                            num_o <= num_q;
                            den_o <= den_q;
                            err_o <= 1'b0;
                        end
                    end
                end
                DIV_NUM:  if (div_done) num_o <= div_quo;
                DIV_DEN: begin
                    if (div_done) begin
                        den_o <= div_quo;
                        err_o <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o  = (state == WAIT_GCD) || (state == DIV_NUM) || (state == DIV_DEN);
    assign valid_o = (state == DONE);

endmodule

// File: tb/tb_frac_reduce.sv
// Scoreboard bench for frac_reduce: directed operand/gcd vectors with
// hand-computed reduced fractions and latencies.
module tb_frac_reduce;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] num;
    logic [W-1:0] den;
    logic         gcd_valid;
    logic [W-1:0] gcd;
    logic         busy_o;
    logic         valid_o;
    logic [W-1:0] num_o;
    logic [W-1:0] den_o;
    logic         err_o;

    typedef struct {
        logic [W-1:0] num;
        logic [W-1:0] den;
        logic         err;
        int           gcd_edge;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    frac_reduce #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .num_i       (num),
        .den_i       (den),
        .gcd_valid_i (gcd_valid),
        .gcd_i       (gcd),
        .busy_o      (busy_o),
        .valid_o     (valid_o),
        .num_o       (num_o),
        .den_o       (den_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every valid_o pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (valid_o) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got num=%0h den=%0h err=%0b expected no result",
                         num_o, den_o, err_o);
            end else begin
                e = sb.pop_front();
                check("num_o", 64'(num_o), 64'(e.num));
                check("den_o", 64'(den_o), 64'(e.den));
                check("err_o", 64'(err_o), 64'(e.err));
                check("latency", 64'(cyc + 1 - e.gcd_edge), 64'(e.lat));
                check("busy_at_done", 64'(busy_o), 64'(0));
            end
        end
    end

    task automatic start_op(input logic [W-1:0] n, input logic [W-1:0] d);
        @(negedge clk);
        start = 1'b1;
        num   = n;
        den   = d;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic gcd_op(input logic [W-1:0] g, input logic [W-1:0] en, input logic [W-1:0] ed,
                          input logic ee, input int lat, input bit push);
        exp_t e;
        @(negedge clk);
        gcd_valid = 1'b1;
        gcd       = g;
        if (push) begin
            e.num      = en;
            e.den      = ed;
            e.err      = ee;
            e.gcd_edge = cyc + 1;
            e.lat      = lat;
            sb.push_back(e);
        end
        @(negedge clk);
        gcd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        num       = '0;
        den       = '0;
        gcd_valid = 1'b0;
        gcd       = '0;
        repeat (3) @(negedge clk);
        check("rst_num_o", 64'(num_o), 64'(0));
        check("rst_den_o", 64'(den_o), 64'(0));
        check("rst_err_o", 64'(err_o), 64'(0));
        check("rst_valid_o", 64'(valid_o), 64'(0));
        check("rst_busy_o", 64'(busy_o), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        start_op(32'd12, 32'd18);
        check("busy_wait_gcd", 64'(busy_o), 64'(1));
        gcd_op(32'd6, 32'd2, 32'd3, 1'b0, 65, 1'b1);
        wait_drain();

        start_op(32'd7, 32'd5);
        gcd_op(32'd1, 32'd7, 32'd5, 1'b0, 1, 1'b1);
        wait_drain();

        start_op(32'd0, 32'd0);
        gcd_op(32'd0, 32'd0, 32'd0, 1'b1, 1, 1'b1);
        wait_drain();

        start_op(32'hFFFF_FFFE, 32'h2);
        gcd_op(32'd2, 32'h7FFF_FFFF, 32'd1, 1'b0, 65, 1'b1);
        wait_drain();

        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        gcd_op(32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 65, 1'b1);
        wait_drain();

        // gcd pulse coincident with start is dropped; a later pulse completes it
        @(negedge clk);
        start     = 1'b1;
        num       = 32'd20;
        den       = 32'd8;
        gcd_valid = 1'b1;
        gcd       = 32'd4;
        @(negedge clk);
        start     = 1'b0;
        gcd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("same_cycle_still_waiting", 64'(busy_o), 64'(1));
        gcd_op(32'd4, 32'd5, 32'd2, 1'b0, 65, 1'b1);
        wait_drain();

        // asynchronous reset in the middle of the numerator division
        start_op(32'd12, 32'd18);
        gcd_op(32'd6, 32'd0, 32'd0, 1'b0, 0, 1'b0);
        repeat (10) @(negedge clk);
        check("busy_mid_div", 64'(busy_o), 64'(1));
        rst = 1'b1;
        #1;
        check("midrst_num_o", 64'(num_o), 64'(0));
        check("midrst_den_o", 64'(den_o), 64'(0));
        check("midrst_err_o", 64'(err_o), 64'(0));
        check("midrst_valid_o", 64'(valid_o), 64'(0));
        check("midrst_busy_o", 64'(busy_o), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (70) @(negedge clk);
        check("after_rst_idle", 64'(busy_o), 64'(0));
        start_op(32'd9, 32'd3);
        gcd_op(32'd3, 32'd3, 32'd1, 1'b0, 65, 1'b1);
        wait_drain();

        // start during DIV_DEN and gcd pulse in IDLE are both ignored
        start_op(32'd12, 32'd18);
        gcd_op(32'd6, 32'd2, 32'd3, 1'b0, 65, 1'b1);
        repeat (40) @(negedge clk);
        check("busy_div_den", 64'(busy_o), 64'(1));
        start = 1'b1;
        num   = 32'd1;
        den   = 32'd1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        @(negedge clk);
        gcd_valid = 1'b1;
        gcd       = 32'd1;
        @(negedge clk);
        gcd_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("hold_num_o", 64'(num_o), 64'(2));
        check("hold_den_o", 64'(den_o), 64'(3));
        check("hold_err_o", 64'(err_o), 64'(0));
        check("hold_idle", 64'(busy_o), 64'(0));

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frac_reduce.md
FRAC_REDUCE -- requirements
Module: frac_reduce

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have port clk_i  input  1  clock, all state on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start_i  input  1  request, latches num_i/den_i (same pulse that starts the upstream gcd).
REQ-005 SHALL have ports num_i, den_i  input  WIDTH  numerator and denominator to reduce.
REQ-006 SHALL have port gcd_valid_i  input  1  one-cycle pulse, gcd_i is valid.
REQ-007 SHALL have port gcd_i  input  WIDTH  gcd(num_i, den_i) from the upstream gcd block.
REQ-008 SHALL have port busy_o  output  1  high in every state except IDLE and DONE.
REQ-009 SHALL have port valid_o  output  1  one-cycle pulse, results valid.
REQ-010 SHALL have ports num_o, den_o  output  WIDTH  reduced numerator and denominator, registered.
REQ-011 SHALL have port err_o  output  1  high with valid_o when gcd_i was 0.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT_GCD, DIV_NUM, DIV_DEN, DONE.
REQ-013 IDLE: when start_i=1, SHALL latch num_i and den_i and go to WAIT_GCD; otherwise stay in IDLE.
REQ-014 WAIT_GCD: when gcd_valid_i=1, SHALL latch gcd_i and branch as follows.
- gcd_i=0: go to DONE, set num_o=0, den_o=0, err_o=1.
- gcd_i=1: go to DONE, set num_o/den_o to the latched operands (bypass).
- otherwise: go to DIV_NUM and load the divider with (num, gcd).
REQ-015 DIV_NUM: SHALL stay exactly WIDTH cycles, then capture the quotient into num_o, load the divider with (den, gcd), and go to DIV_DEN.
REQ-016 DIV_DEN: SHALL stay exactly WIDTH cycles, then capture the quotient into den_o and go to DONE.
REQ-017 DONE: SHALL assert valid_o for one cycle and go to IDLE; err_o SHALL equal 0 except in the gcd_i=0 case.
REQ-018 Latency from the edge sampling gcd_valid_i to valid_o high SHALL be:
- 1 cycle in both bypass cases (gcd_i=0, gcd_i=1);
- 2*WIDTH+1 cycles otherwise.
REQ-019 Division SHALL be unsigned restoring shift-subtract, one quotient bit per cycle, MSB first; remainder discarded.
REQ-020 start_i SHALL be ignored outside IDLE.
REQ-021 gcd_valid_i SHALL be ignored outside WAIT_GCD.
REQ-022 start_i and gcd_valid_i high in the same IDLE cycle SHALL only latch operands; the gcd pulse is lost by design.
REQ-023 num_o, den_o and err_o SHALL hold their values until the next DONE.
REQ-024 The bench SHALL never present a gcd_i that does not divide both operands; behaviour in that case is quotient truncation, no error flag.

Reset
REQ-025 rst_i high SHALL force IDLE immediately, including mid-division.
REQ-026 During and after reset, num_o, den_o, err_o, valid_o and busy_o SHALL read 0, and latched operands, gcd and divider state SHALL read 0.
REQ-027 After rst_i deasserts, the first accepted start_i SHALL behave identically to a start from power-up.

Structure
REQ-028 SHALL place the FSM state enum, the divider-control enum and the default WIDTH constant in shared package frac_pkg.
REQ-029 The divider SHALL be sub-module div_serial with the following ports:
- clk_i, rst_i;
- load_i, dividend_i, divisor_i;
- quotient_o, done_o (pulse after WIDTH cycles).
REQ-030 frac_reduce SHALL instantiate exactly one div_serial, reused for both divisions.

Verification
REQ-031 start num=12, den=18; gcd_valid_i with gcd=6 -> num_o=2, den_o=3, err_o=0, valid_o exactly 65 cycles after the gcd edge.
REQ-032 num=7, den=5, gcd=1 -> num_o=7, den_o=5, valid_o 1 cycle after the gcd edge; DIV states never entered.
REQ-033 num=0, den=0, gcd=0 -> num_o=0, den_o=0, err_o=1, valid_o after 1 cycle.
REQ-034 num=0xFFFFFFFE, den=0x2, gcd=2 -> num_o=0x7FFFFFFF, den_o=1.
REQ-035 rst_i pulsed 10 cycles into DIV_NUM -> all outputs 0, state IDLE; a following start with num=9, den=3, gcd=3 yields 3/1.
REQ-036 start_i pulsed during DIV_DEN and gcd_valid_i pulsed in IDLE -> both ignored; the current result is unchanged.
